// File: rtl/kudu_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kudu_sim_ctrl
// Purpose  : Memory-mapped simulation-control responder. Decodes core stores
//            to a four-register window and drives the stats collector's
//            start_stop toggle pulse and print_req level, mirrors the
//            collector's count window in a cycle counter, and sequences a
//            clean simulation exit (stop counting, print, signal done).
// Revision : 1.0 - initial release
// ============================================================================
module kudu_sim_ctrl #(
  parameter int unsigned PRINT_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        start_stop_o,
  output logic        print_req_o,
  output logic        sim_done_o,
  output logic [7:0]  sim_code_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRINT_HI  = 3'd1,
    ST_PRINT_GAP = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_CYCLES  = 2'd1;
  localparam logic [1:0] REG_EXIT    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  // Hold counter counts down from PRINT_HOLD-1 to 0 while print_req is high.
  localparam int unsigned       HOLD_W    = (PRINT_HOLD > 1) ? $clog2(PRINT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PRINT_HOLD - 1);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               exit_pending;
  logic               exit_stage;
  logic               enabled;
  logic [31:0]        cycles;
  logic [31:0]        scratch;

  logic [1:0]         reg_sel;
  logic               wr_acc;
  logic               rd_acc;
  logic               ctrl_wr;
  logic               cycles_wr;
  logic               exit_wr;
  logic               scratch_wr;
  logic               cmd_ok;
  logic               start_ok;
  logic               stop_ok;
  logic               print_ok;
  logic               exit_ok;
  logic               busy;
  logic [31:0]        rd_mux;
  logic               unused_addr;

  // Only word offsets are decoded; the byte-lane bits are deliberately ignored.
  assign reg_sel     = addr_i[3:2];
  assign unused_addr = ^addr_i[1:0];

  // The responder never stalls the bus.
  assign gnt_o = req_i;

  assign busy = (state != ST_IDLE);

  // Decode the bus access into per-register strobes and command qualifiers.
  always_comb begin
    wr_acc     = req_i & we_i;
    rd_acc     = req_i & ~we_i;
    ctrl_wr    = wr_acc && (reg_sel == REG_CTRL);
    cycles_wr  = wr_acc && (reg_sel == REG_CYCLES);
    exit_wr    = wr_acc && (reg_sel == REG_EXIT);
    scratch_wr = wr_acc && (reg_sel == REG_SCRATCH);
    // Commands are only honoured when nothing is in flight and no exit waits.
    cmd_ok     = (state == ST_IDLE) && !exit_pending;
    // START and STOP together cancel out; each only acts if it changes state.
    start_ok   = ctrl_wr && cmd_ok && wdata_i[0] && !wdata_i[1] && !enabled;
    stop_ok    = ctrl_wr && cmd_ok && wdata_i[1] && !wdata_i[0] &&  enabled;
    print_ok   = ctrl_wr && cmd_ok && wdata_i[2];
    // The first EXIT code wins; nothing is accepted once the run is over.
    exit_ok    = exit_wr && !exit_pending && (state != ST_DONE);
  end

  // Select the read-back value for the addressed register.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      REG_CTRL:    rd_mux = {29'd0, exit_pending, busy, enabled};
      REG_CYCLES:  rd_mux = cycles;
      REG_EXIT:    rd_mux = {24'd0, sim_code_o};
      REG_SCRATCH: rd_mux = scratch;
      default:     rd_mux = 32'd0;
    endcase
  end

  // Sequencer for print and exit handshakes with registered collector controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      exit_pending <= 1'b0;
      exit_stage   <= 1'b0;
      start_stop_o <= 1'b0;
      print_req_o  <= 1'b0;
      sim_done_o   <= 1'b0;
      sim_code_o   <= 8'd0;
    end else begin
      // start_stop is a single-cycle pulse unless a branch below re-asserts it.
      start_stop_o <= 1'b0;

      if (exit_ok) begin
        exit_pending <= 1'b1;
        sim_code_o   <= wdata_i[7:0];
      end

      case (state)
        ST_IDLE: begin
          if (exit_pending) begin
            state        <= ST_STOP_WAIT;
            start_stop_o <= enabled;
          end else begin
            start_stop_o <= start_ok | stop_ok;
            if (print_ok) begin
              state       <= ST_PRINT_HI;
              print_req_o <= 1'b1;
              hold_cnt    <= HOLD_LAST;
            end
          end
        end

        ST_PRINT_HI: begin
          if (hold_cnt == '0) begin
            state       <= ST_PRINT_GAP;
            print_req_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        // One low cycle guarantees the collector sees a fresh rising edge.
        ST_PRINT_GAP: begin
          if (exit_stage) begin
            state      <= ST_DONE;
            sim_done_o <= 1'b1;
          end else if (exit_pending) begin
            state        <= ST_STOP_WAIT;
            start_stop_o <= enabled;
          end else begin
            state <= ST_IDLE;
          end
        end

        // Counting is stopped (if running); the final dump follows.
        ST_STOP_WAIT: begin
          state        <= ST_PRINT_HI;
          print_req_o  <= 1'b1;
          hold_cnt     <= HOLD_LAST;
          exit_pending <= 1'b0;
          exit_stage   <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Count-enable mirror, cycle counter, scratch register and bus response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enabled  <= 1'b0;
      cycles   <= 32'd0;
      scratch  <= 32'd0;
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
    end else begin
      // The collector toggles on every pulse, so the mirror does too.
      enabled <= enabled ^ start_stop_o;

      // A software clear wins over the increment in the same cycle.
      if (cycles_wr) begin
        cycles <= 32'd0;
      end else if (enabled) begin
        cycles <= cycles + 32'd1;
      end

      if (scratch_wr) begin
        scratch <= wdata_i;
      end

      rvalid_o <= req_i;
      rdata_o  <= rd_acc ? rd_mux : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kudu_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kudu_sim_ctrl
// Purpose  : Self-checking bench for kudu_sim_ctrl. A timeline model books
//            the expected collector pulses and print windows per cycle and
//            every cycle's outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kudu_sim_ctrl;

  localparam int H    = 4;
  localparam int MAXC = 4096;
  localparam int NEVER = 1 << 30;

  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        start_stop_o;
  logic        print_req_o;
  logic        sim_done_o;
  logic [7:0]  sim_code_o;

  kudu_sim_ctrl #(.PRINT_HOLD(H)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .start_stop_o (start_stop_o),
    .print_req_o  (print_req_o),
    .sim_done_o   (sim_done_o),
    .sim_code_o   (sim_code_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Timeline model: expected pulse/print level per cycle plus register state.
  bit          m_ss [MAXC];
  bit          m_pr [MAXC];
  bit          m_en;
  bit          m_pend;
  bit          m_exit_started;
  logic [31:0] m_cycles;
  logic [31:0] m_scratch;
  logic [7:0]  m_code;
  int          m_gap;
  int          m_done_from;
  int          m_pend_clear_at;
  int          cyc;
  bit          e_rvalid;
  logic [31:0] e_rdata;

  int n_ss;
  int n_pr_hi;
  int n_pr_rise;
  bit prev_pr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) begin
      m_ss[i] = 1'b0;
      m_pr[i] = 1'b0;
    end
    m_en            = 1'b0;
    m_pend          = 1'b0;
    m_exit_started  = 1'b0;
    m_cycles        = 32'd0;
    m_scratch       = 32'd0;
    m_code          = 8'd0;
    m_gap           = -1;
    m_done_from     = NEVER;
    m_pend_clear_at = -1;
    cyc             = 0;
    e_rvalid        = 1'b0;
    e_rdata         = 32'd0;
    prev_pr         = 1'b0;
  endtask

  // Advance the model across one clock edge given the request presented before it.
  task automatic model_edge(input bit rq, input bit we, input logic [1:0] a, input logic [31:0] wd);
    int c;
    int n;
    bit en_c;
    bit pend_c;
    bit busy_c;
    bit done_c;
    bit is_wr;
    c      = cyc;
    n      = cyc + 1;
    if (n + H + 3 >= MAXC) begin
      $display("FAIL model_overflow cycle=%0d limit=%0d", n, MAXC);
      $fatal(1, "model timeline exhausted");
    end
    en_c   = m_en;
    pend_c = m_pend;
    busy_c = (c <= m_gap) || m_exit_started;
    done_c = (c >= m_done_from);
    is_wr  = rq && we;

    e_rvalid = rq;
    e_rdata  = 32'd0;
    if (rq && !we) begin
      case (a)
        2'd0:    e_rdata = {29'd0, pend_c, busy_c, en_c};
        2'd1:    e_rdata = m_cycles;
        2'd2:    e_rdata = {24'd0, m_code};
        default: e_rdata = m_scratch;
      endcase
    end

    m_en = en_c ^ m_ss[c];
    if (is_wr && a == 2'd1) m_cycles = 32'd0;
    else if (en_c)          m_cycles = m_cycles + 32'd1;
    if (is_wr && a == 2'd3) m_scratch = wd;

    if (pend_c && !m_exit_started && c >= m_gap) begin
      // Exit: stop pulse now (if counting), final print next, done after its gap.
      m_exit_started = 1'b1;
      m_ss[n] = en_c;
      for (int k = 1; k <= H; k++) m_pr[n + k] = 1'b1;
      m_done_from     = n + H + 2;
      m_pend_clear_at = n + 1;
    end else if (is_wr && a == 2'd0 && !busy_c && !pend_c) begin
      if ((wd[0] && !wd[1] && !en_c) || (wd[1] && !wd[0] && en_c)) m_ss[n] = 1'b1;
      if (wd[2]) begin
        for (int k = 0; k < H; k++) m_pr[n + k] = 1'b1;
        m_gap = n + H;
      end
    end

    if (n == m_pend_clear_at) m_pend = 1'b0;
    if (is_wr && a == 2'd2 && !pend_c && !done_c) begin
      m_pend = 1'b1;
      m_code = wd[7:0];
    end
    cyc = n;
  endtask

  task automatic check_outputs();
    chk("rvalid",     32'(rvalid_o),     32'(e_rvalid));
    chk("rdata",      rdata_o,           e_rdata);
    chk("start_stop", 32'(start_stop_o), 32'(m_ss[cyc]));
    chk("print_req",  32'(print_req_o),  32'(m_pr[cyc]));
    chk("sim_done",   32'(sim_done_o),   32'(cyc >= m_done_from));
    chk("sim_code",   32'(sim_code_o),   32'(m_code));
    if (start_stop_o) n_ss++;
    if (print_req_o) begin
      n_pr_hi++;
      if (!prev_pr) n_pr_rise++;
    end
    prev_pr = print_req_o;
  endtask

  // One bus cycle: drive at the falling edge, check results at the next one.
  task automatic step(input bit rq, input bit we, input logic [3:0] addr, input logic [31:0] wd);
    req_i   = rq;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    #1;
    chk("gnt", 32'(gnt_o), 32'(rq));
    model_edge(rq, we, addr[3:2], wd);
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, {a, 2'b00}, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b0, {a, 2'b00}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 4'd0;
    wdata_i = 32'd0;
    repeat (2) @(negedge clk_i);
    chk("rst_rvalid",     32'(rvalid_o),     32'd0);
    chk("rst_rdata",      rdata_o,           32'd0);
    chk("rst_start_stop", 32'(start_stop_o), 32'd0);
    chk("rst_print_req",  32'(print_req_o),  32'd0);
    chk("rst_sim_done",   32'(sim_done_o),   32'd0);
    chk("rst_sim_code",   32'(sim_code_o),   32'd0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int ss0;
    int pr0;
    int rise0;
    bit          r_rq;
    bit          r_we;
    logic [1:0]  r_a;
    logic [31:0] r_wd;

    rst_ni  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 4'd0;
    wdata_i = 32'd0;
    n_ss = 0; n_pr_hi = 0; n_pr_rise = 0;
    model_reset();
    do_reset();

    // Randomised traffic; EXIT writes are rare so most of the run stays live.
    for (int i = 0; i < 600; i++) begin
      r_rq = ($urandom_range(0, 3) != 0);
      r_we = ($urandom_range(0, 1) != 0);
      r_a  = 2'($urandom_range(0, 3));
      r_wd = $urandom;
      if (r_a == 2'd2 && r_we && $urandom_range(0, 39) != 0) r_a = 2'd3;
      if (r_a == 2'd1 && r_we && $urandom_range(0, 3) != 0) r_we = 1'b0;
      step(r_rq, r_we, {r_a, 2'($urandom_range(0, 3))}, r_wd);
    end

    do_reset();

    // START, ten idle cycles, STOP: two pulses, 11 counted cycles.
    ss0 = n_ss;
    wr(2'd0, 32'h1);
    chk("start_pulse", 32'(start_stop_o), 32'd1);
    idle(10);
    wr(2'd0, 32'h2);
    chk("stop_pulse", 32'(start_stop_o), 32'd1);
    idle(1);
    rd(2'd1);
    chk("cycles_11", rdata_o, 32'd11);
    chk("pulses_2", 32'(n_ss - ss0), 32'd2);

    // Redundant START and START+STOP produce no extra pulses.
    wr(2'd1, 32'h0);
    ss0 = n_ss;
    wr(2'd0, 32'h1);
    idle(2);
    wr(2'd0, 32'h1);
    idle(2);
    wr(2'd0, 32'h3);
    idle(2);
    rd(2'd0);
    chk("ctrl_enabled", rdata_o, 32'h1);
    chk("pulses_1", 32'(n_ss - ss0), 32'd1);

    // PRINT, then a second PRINT while busy is dropped.
    pr0 = n_pr_hi; rise0 = n_pr_rise;
    wr(2'd0, 32'h4);
    idle(1);
    wr(2'd0, 32'h4);
    rd(2'd0);
    chk("ctrl_busy", rdata_o, 32'h3);
    idle(6);
    chk("print_len", 32'(n_pr_hi - pr0), 32'(H));
    chk("print_rise", 32'(n_pr_rise - rise0), 32'd1);

    // Counter wrap and clear-versus-increment priority.
    force dut.cycles = 32'hFFFF_FFFE;
    #1;
    release dut.cycles;
    m_cycles = 32'hFFFF_FFFE;
    rd(2'd1);
    rd(2'd1);
    chk("wrap_hi", rdata_o, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("wrap_zero", rdata_o, 32'd0);
    wr(2'd1, 32'hABCD_0123);
    rd(2'd1);
    chk("clear_prio", rdata_o, 32'd0);

    // EXIT during a print, then a second EXIT: first code wins, two dumps.
    rise0 = n_pr_rise;
    wr(2'd0, 32'h4);
    wr(2'd2, 32'h11);
    wr(2'd2, 32'h22);
    idle(16);
    chk("exit_done", 32'(sim_done_o), 32'd1);
    chk("exit_code", 32'(sim_code_o), 32'h11);
    chk("exit_rises", 32'(n_pr_rise - rise0), 32'd2);
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3);
    chk("scratch_done", rdata_o, 32'hDEAD_BEEF);
    ss0 = n_ss;
    wr(2'd0, 32'h1);
    idle(2);
    chk("done_no_pulse", 32'(n_ss - ss0), 32'd0);

    // Asynchronous reset in the middle of a print drops everything at once.
    do_reset();
    wr(2'd0, 32'h4);
    idle(1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_print_req", 32'(print_req_o), 32'd0);
    chk("async_sim_done",  32'(sim_done_o),  32'd0);
    chk("async_rvalid",    32'(rvalid_o),    32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    rd(2'd0);
    chk("post_rst_ctrl", rdata_o, 32'd0);
    idle(8);

    // Clean exit while counting: stop pulse, one dump, done at E+7.
    wr(2'd0, 32'h1);
    idle(2);
    ss0 = n_ss; pr0 = n_pr_hi;
    wr(2'd2, 32'h5A);
    idle(1);
    chk("exit_stop_pulse", 32'(start_stop_o), 32'd1);
    idle(5);
    chk("done_e6", 32'(sim_done_o), 32'd0);
    idle(1);
    chk("done_e7", 32'(sim_done_o), 32'd1);
    chk("code_5a", 32'(sim_code_o), 32'h5A);
    chk("exit_print_len", 32'(n_pr_hi - pr0), 32'(H));
    wr(2'd0, 32'h1);
    idle(2);
    chk("exit_pulses", 32'(n_ss - ss0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
